// File: rtl/keccak_state_sequencer_pkg.sv
// keccak_seq_pkg: constants and the FSM state type shared by the Keccak state
// sequencer and its state bank.
//   NUM_ROUNDS  default permutation length (Keccak-f[1600] = 24 rounds)
//   NUM_WORDS   32-bit words in the 1600-bit state (32 main + 18 gp)
package keccak_seq_pkg;
  localparam int NUM_ROUNDS = 24;
  localparam int NUM_WORDS  = 50;
  localparam int WORD_W     = 32;
  localparam int MAIN_WORDS = 32;
  localparam int GP_WORDS   = 18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;
endpackage

// File: rtl/keccak_state_bank.sv
// keccak_state_bank: 50 x 32-bit Keccak state storage.
//   clock, reset_n  rising-edge clock, synchronous active-low clear
//   cpu_wr_en       qualified CPU write (already gated by busy)
//   cpu_addr/wdata  CPU word index and data; cpu_rdata is a combinational read,
//                   zero for indices >= 50
//   hash_we/wdata   per-word write-back from the hashes round logic
//   rdata_main/gp   state packed as words 0..31 and 32..49, word k at [32k+31:32k]
// A hash write-back and a CPU write to the same word in one cycle: hash wins.
module keccak_state_bank
  import keccak_seq_pkg::*;
(
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 cpu_wr_en,
  input  logic [5:0]                           cpu_addr,
  input  logic [WORD_W-1:0]                    cpu_wdata,
  output logic [WORD_W-1:0]                    cpu_rdata,
  input  logic [NUM_WORDS-1:0]                 hash_we,
  input  logic [NUM_WORDS-1:0][WORD_W-1:0]     hash_wdata,
  output logic [MAIN_WORDS*WORD_W-1:0]         rdata_main,
  output logic [GP_WORDS*WORD_W-1:0]           rdata_gp
);
  logic [NUM_WORDS-1:0][WORD_W-1:0] mem_q;

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (!reset_n)
        mem_q[i] <= '0;
      else if (hash_we[i])
        mem_q[i] <= hash_wdata[i];
      else if (cpu_wr_en && cpu_addr == 6'(i))
        mem_q[i] <= cpu_wdata;
    end
  end

  // Decoded read: indices 50..63 match no word and fall through to zero.
  always_comb begin
    cpu_rdata = '0;
    for (int i = 0; i < NUM_WORDS; i++)
      if (cpu_addr == 6'(i)) cpu_rdata = mem_q[i];
  end

  assign rdata_main = mem_q[MAIN_WORDS-1:0];
  assign rdata_gp   = mem_q[NUM_WORDS-1:MAIN_WORDS];
endmodule

// File: rtl/keccak_state_sequencer.sv
// keccak_state_sequencer: owns the 1600-bit Keccak state and steps the hashes
// datapath through NUM_ROUNDS rounds per permutation.
//   clock, reset_n         rising-edge clock, synchronous active-low reset
//   cpu_we/addr/wdata      CPU word load (accepted only while not busy)
//   cpu_rdata              combinational word read, legal at any time
//   start                  one-cycle permutation request, honoured in IDLE only
//   busy, done             RUN indicator / one-cycle completion pulse
//   keccak_f_start         round-active strobe (hashes write-enable source)
//   keccak_round           current round index
//   keccak_rst             round-logic reset, high whenever not in RUN
//   rdata_hash_*_vector    state presented to the hashes block
//   wdata_hash_*/we_hash_* round results and per-word enables from hashes
// Optional macro KECCAK_ABORT_EN adds an abort input that drops RUN back to
// IDLE without a done pulse.
module keccak_state_sequencer #(
  parameter int NUM_ROUNDS = keccak_seq_pkg::NUM_ROUNDS
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          cpu_we,
  input  logic [5:0]    cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  input  logic          start,
`ifdef KECCAK_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          done,
  output logic          keccak_f_start,
  output logic [4:0]    keccak_round,
  output logic          keccak_rst,
  output logic [1023:0] rdata_hash_i_vector,
  output logic [575:0]  rdata_hash_gp_i_vector,
  input  logic [1023:0] wdata_hash_o_vector,
  input  logic [31:0]   we_hash_o,
  input  logic [575:0]  wdata_hash_gp_o_vector,
  input  logic [17:0]   we_hash_gp_o
);
  import keccak_seq_pkg::*;

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);

  seq_state_t state_q;
  logic [4:0] round_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      round_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_RUN;
          round_q <= '0;
        end
        ST_RUN: begin
`ifdef KECCAK_ABORT_EN
          if (abort) begin
            state_q <= ST_IDLE;
            round_q <= '0;
          end else
`endif
          if (round_q == LAST_ROUND) begin
            state_q <= ST_DONE;
            round_q <= '0;
          end else begin
            round_q <= round_q + 5'd1;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: begin
          state_q <= ST_IDLE;
          round_q <= '0;
        end
      endcase
    end
  end

  assign busy           = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign keccak_f_start = busy;
  assign keccak_rst     = !busy;
  assign keccak_round   = round_q;

  keccak_state_bank u_bank (
    .clock      (clock),
    .reset_n    (reset_n),
    .cpu_wr_en  (cpu_we && !busy),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .hash_we    ({we_hash_gp_o, we_hash_o}),
    .hash_wdata ({wdata_hash_gp_o_vector, wdata_hash_o_vector}),
    .rdata_main (rdata_hash_i_vector),
    .rdata_gp   (rdata_hash_gp_i_vector)
  );
endmodule

// File: tb/tb_keccak_state_sequencer.sv
module tb_keccak_state_sequencer;
  localparam int NR = 24;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          cpu_we;
  logic [5:0]    cpu_addr;
  logic [31:0]   cpu_wdata;
  logic [31:0]   cpu_rdata;
  logic          start;
`ifdef KECCAK_ABORT_EN
  logic          abort;
`endif
  logic          busy, done, keccak_f_start, keccak_rst;
  logic [4:0]    keccak_round;
  logic [1023:0] rdata_hash_i_vector;
  logic [575:0]  rdata_hash_gp_i_vector;
  logic [1023:0] wdata_hash_o_vector;
  logic [31:0]   we_hash_o;
  logic [575:0]  wdata_hash_gp_o_vector;
  logic [17:0]   we_hash_gp_o;

  int total = 0;
  int bad   = 0;

  // Reference state: what the 50 words should hold, plus whether the block is
  // in its round-issuing phase during the cycle about to end.
  logic [31:0] mdl [50];
  logic        mdl_busy;

  always #5 clock = ~clock;

  keccak_state_sequencer #(.NUM_ROUNDS(NR)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .start(start),
`ifdef KECCAK_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .keccak_f_start(keccak_f_start),
    .keccak_round(keccak_round), .keccak_rst(keccak_rst),
    .rdata_hash_i_vector(rdata_hash_i_vector), .rdata_hash_gp_i_vector(rdata_hash_gp_i_vector),
    .wdata_hash_o_vector(wdata_hash_o_vector), .we_hash_o(we_hash_o),
    .wdata_hash_gp_o_vector(wdata_hash_gp_o_vector), .we_hash_gp_o(we_hash_gp_o)
  );

  function automatic logic [1023:0] exp_main();
    logic [1023:0] v;
    for (int k = 0; k < 32; k++) v[32*k +: 32] = mdl[k];
    return v;
  endfunction

  function automatic logic [575:0] exp_gp();
    logic [575:0] v;
    for (int k = 0; k < 18; k++) v[32*k +: 32] = mdl[32+k];
    return v;
  endfunction

  // Apply this edge's writes to the reference, then advance past the edge.
  task automatic tick();
    for (int i = 0; i < 50; i++) begin
      logic        hwe;
      logic [31:0] hd;
      if (i < 32) begin hwe = we_hash_o[i];       hd = wdata_hash_o_vector[32*i +: 32]; end
      else        begin hwe = we_hash_gp_o[i-32]; hd = wdata_hash_gp_o_vector[32*(i-32) +: 32]; end
      if (!reset_n)                                   mdl[i] = '0;
      else if (hwe)                                   mdl[i] = hd;
      else if (cpu_we && !mdl_busy && int'(cpu_addr) == i) mdl[i] = cpu_wdata;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; start = 0;
`ifdef KECCAK_ABORT_EN
    abort = 0;
`endif
    we_hash_o = 0; we_hash_gp_o = 0;
    wdata_hash_o_vector = 0; wdata_hash_gp_o_vector = 0;
  endtask

  task automatic rand_stim();
    for (int k = 0; k < 32; k++) wdata_hash_o_vector[32*k +: 32] = $urandom;
    for (int k = 0; k < 18; k++) wdata_hash_gp_o_vector[32*k +: 32] = $urandom;
    we_hash_o    = $urandom & $urandom;
    we_hash_gp_o = 18'($urandom & $urandom);
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_addr  = 6'($urandom_range(0, 63));
    cpu_wdata = $urandom;
  endtask

  task automatic test_reset();
    reset_n = 0; rand_stim(); mdl_busy = 0;
    tick(); tick();
    total++; if (busy !== 1'b0)           begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)           begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (keccak_rst !== 1'b1)     begin bad++; $display("FAIL reset_krst got=%b want=1", keccak_rst); end
    total++; if (keccak_f_start !== 1'b0) begin bad++; $display("FAIL reset_fstart got=%b want=0", keccak_f_start); end
    total++; if (keccak_round !== 5'd0)   begin bad++; $display("FAIL reset_round got=%0d want=0", keccak_round); end
    total++; if (rdata_hash_i_vector !== '0) begin bad++; $display("FAIL reset_main got=%h want=0", rdata_hash_i_vector); end
    total++; if (rdata_hash_gp_i_vector !== '0) begin bad++; $display("FAIL reset_gp got=%h want=0", rdata_hash_gp_i_vector); end
    quiet(); reset_n = 1;
    for (int a = 0; a < 64; a++) begin
      cpu_addr = 6'(a); #1;
      total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL reset_rd addr=%0d got=%h want=0", a, cpu_rdata); end
    end
    tick();
  endtask

  task automatic test_cpu_port();
    quiet(); mdl_busy = 0;
    cpu_we = 1; cpu_addr = 7;  cpu_wdata = 32'hDEADBEEF; tick();
    cpu_addr = 49; cpu_wdata = 32'h12345678; tick();
    cpu_addr = 50; cpu_wdata = 32'hFFFFFFFF; tick();
    cpu_we = 0;
    cpu_addr = 7; #1;
    total++; if (cpu_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_rd7 got=%h want=deadbeef", cpu_rdata); end
    cpu_addr = 49; #1;
    total++; if (cpu_rdata !== 32'h12345678) begin bad++; $display("FAIL cpu_rd49 got=%h want=12345678", cpu_rdata); end
    cpu_addr = 50; #1;
    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL cpu_rd50 got=%h want=0", cpu_rdata); end
    total++; if (rdata_hash_i_vector[255:224] !== 32'hDEADBEEF)
      begin bad++; $display("FAIL cpu_vec7 got=%h want=deadbeef", rdata_hash_i_vector[255:224]); end
    total++; if (rdata_hash_gp_i_vector[575:544] !== 32'h12345678)
      begin bad++; $display("FAIL cpu_vec49 got=%h want=12345678", rdata_hash_gp_i_vector[575:544]); end
    // Random fill of every word through the CPU port.
    cpu_we = 1;
    for (int a = 0; a < 50; a++) begin cpu_addr = 6'(a); cpu_wdata = $urandom; tick(); end
    cpu_we = 0;
    total++; if (rdata_hash_i_vector !== exp_main()) begin bad++; $display("FAIL cpu_fill_main got=%h want=%h", rdata_hash_i_vector, exp_main()); end
    total++; if (rdata_hash_gp_i_vector !== exp_gp()) begin bad++; $display("FAIL cpu_fill_gp got=%h want=%h", rdata_hash_gp_i_vector, exp_gp()); end
  endtask

  // One full permutation with random write-backs and CPU traffic every cycle.
  // restart_at: round index at which a stray start pulse is injected (or -1).
  task automatic run_perm(input int restart_at);
    int r_bad = 0;
    quiet(); rand_stim(); start = 1; mdl_busy = 0;
    tick();
    for (int r = 0; r < NR; r++) begin
      if (busy !== 1'b1 || keccak_f_start !== 1'b1 || keccak_rst !== 1'b0 ||
          done !== 1'b0 || keccak_round !== 5'(r)) begin
        r_bad++;
        $display("FAIL seq_round r=%0d got busy=%b fs=%b rst=%b done=%b round=%0d", r,
                 busy, keccak_f_start, keccak_rst, done, keccak_round);
      end
      rand_stim(); #1;
      if (cpu_rdata !== (int'(cpu_addr) < 50 ? mdl[cpu_addr] : 32'h0)) begin
        r_bad++;
        $display("FAIL seq_rd r=%0d addr=%0d got=%h", r, cpu_addr, cpu_rdata);
      end
      start = (r == restart_at); mdl_busy = 1;
      tick();
    end
    total++; if (r_bad != 0) bad++;
    total++; if (done !== 1'b1 || busy !== 1'b0 || keccak_rst !== 1'b1 || keccak_f_start !== 1'b0 || keccak_round !== 5'd0)
      begin bad++; $display("FAIL seq_done got done=%b busy=%b rst=%b fs=%b round=%0d want 1 0 1 0 0", done, busy, keccak_rst, keccak_f_start, keccak_round); end
    total++; if (rdata_hash_i_vector !== exp_main()) begin bad++; $display("FAIL seq_main got=%h want=%h", rdata_hash_i_vector, exp_main()); end
    total++; if (rdata_hash_gp_i_vector !== exp_gp()) begin bad++; $display("FAIL seq_gp got=%h want=%h", rdata_hash_gp_i_vector, exp_gp()); end
  endtask

  task automatic test_sequencing();
    run_perm(5);
    // start during the done cycle must not launch or queue a run
    quiet(); start = 1; mdl_busy = 0; tick(); start = 0;
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL seq_after got done=%b busy=%b want 0 0", done, busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL seq_noqueue got busy=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      run_perm(-1);
      quiet(); mdl_busy = 0; tick();   // done -> idle
    end
  endtask

  task automatic test_partial_enables();
    logic [1023:0] before_m;
    logic [575:0]  before_g;
    quiet(); start = 1; mdl_busy = 0; tick(); start = 0;
    before_m = rdata_hash_i_vector; before_g = rdata_hash_gp_i_vector;
    for (int k = 0; k < 32; k++) wdata_hash_o_vector[32*k +: 32] = $urandom;
    wdata_hash_o_vector[31:0] = 32'hA5A5A5A5;
    we_hash_o = 32'h1; we_hash_gp_o = 0;
    cpu_we = 1; cpu_addr = 3; cpu_wdata = 32'h0BADF00D; mdl_busy = 1;
    tick();
    total++; if (rdata_hash_i_vector !== {before_m[1023:32], 32'hA5A5A5A5})
      begin bad++; $display("FAIL part_main got=%h want=%h", rdata_hash_i_vector, {before_m[1023:32], 32'hA5A5A5A5}); end
    total++; if (rdata_hash_gp_i_vector !== before_g) begin bad++; $display("FAIL part_gp got=%h want=%h", rdata_hash_gp_i_vector, before_g); end
    quiet();
    for (int r = 1; r < NR; r++) tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL part_done got=%b want=1", done); end
    mdl_busy = 0; tick();
    // Idle: CPU and hash both target word 0 in the same cycle.
    wdata_hash_o_vector[31:0] = 32'h5A5A5A5A; we_hash_o = 32'h1;
    cpu_we = 1; cpu_addr = 0; cpu_wdata = 32'h11111111;
    tick(); quiet(); cpu_addr = 0; #1;
    total++; if (cpu_rdata !== 32'h5A5A5A5A) begin bad++; $display("FAIL part_prio got=%h want=5a5a5a5a", cpu_rdata); end
  endtask

  task automatic test_reset_mid_run();
    int seen_done = 0;
    quiet(); start = 1; mdl_busy = 0; tick();
    for (int r = 0; r < 10; r++) begin rand_stim(); start = 0; mdl_busy = 1; tick(); end
    total++; if (keccak_round !== 5'd10) begin bad++; $display("FAIL mid_round got=%0d want=10", keccak_round); end
    quiet(); reset_n = 0; tick(); reset_n = 1; mdl_busy = 0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || keccak_round !== 5'd0)
      begin bad++; $display("FAIL mid_state got busy=%b done=%b round=%0d want 0 0 0", busy, done, keccak_round); end
    total++; if (rdata_hash_i_vector !== '0 || rdata_hash_gp_i_vector !== '0)
      begin bad++; $display("FAIL mid_clear got main=%h gp=%h want 0", rdata_hash_i_vector, rdata_hash_gp_i_vector); end
    for (int c = 0; c < NR + 3; c++) begin if (done === 1'b1 || busy === 1'b1) seen_done++; tick(); end
    total++; if (seen_done != 0) begin bad++; $display("FAIL mid_nodone got=%0d cycles want=0", seen_done); end
  endtask

`ifdef KECCAK_ABORT_EN
  task automatic test_abort();
    int seen_done = 0;
    quiet(); start = 1; mdl_busy = 0; tick();
    for (int r = 0; r < 3; r++) begin rand_stim(); start = 0; mdl_busy = 1; tick(); end
    total++; if (keccak_round !== 5'd3) begin bad++; $display("FAIL abort_round got=%0d want=3", keccak_round); end
    rand_stim(); abort = 1; tick(); quiet(); mdl_busy = 0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || keccak_rst !== 1'b1)
      begin bad++; $display("FAIL abort_state got busy=%b done=%b rst=%b want 0 0 1", busy, done, keccak_rst); end
    total++; if (rdata_hash_i_vector !== exp_main() || rdata_hash_gp_i_vector !== exp_gp())
      begin bad++; $display("FAIL abort_bank got main=%h want=%h", rdata_hash_i_vector, exp_main()); end
    abort = 1;   // outside RUN: no effect
    for (int c = 0; c < NR + 2; c++) begin if (done === 1'b1 || busy === 1'b1) seen_done++; tick(); end
    abort = 0;
    total++; if (seen_done != 0) begin bad++; $display("FAIL abort_nodone got=%0d cycles want=0", seen_done); end
  endtask
`endif

  initial begin
    quiet(); reset_n = 0; mdl_busy = 0;
    for (int i = 0; i < 50; i++) mdl[i] = $urandom;
    test_reset();
    test_cpu_port();
    test_sequencing();
    test_back_to_back();
    test_partial_enables();
    test_reset_mid_run();
`ifdef KECCAK_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
